// File: rtl/cmp_share_arbiter.sv
// Purpose: round-robin share of one 8-bit magnitude comparator between NUM_REQ requesters.
// Latency: accept in cycle N, comparator sampled in N+1, one-cycle rsp_valid pulse in N+2.
// Backpressure: req_ready only in IDLE/RESP (one comparison per 2 cycles); responses cannot be stalled.
module cmp_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         cmp_a,
  output logic [DATA_W-1:0]         cmp_b,
  input  logic                      cmp_gt,
  input  logic                      cmp_eq,
  input  logic                      cmp_lt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_gt,
  output logic                      rsp_eq,
  output logic                      rsp_lt,
  output logic                      busy,
  output logic                      err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [PTR_W-1:0]   owner_id;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W:0]     scan_sum;
  logic               grant_found;
  logic [NUM_REQ-1:0] grant_vec;
  logic               accept_en;
  logic               accept;
  logic [2:0]         cmp_triple;
  logic               cmp_onehot;

  // Unpack the flattened operand buses so a requester index selects a whole operand.
  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*DATA_W +: DATA_W];
    assign op_b[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // New work is taken only when no comparison is in flight; reset forces ready low.
  assign accept_en = rst_n && ((state == ST_IDLE) || (state == ST_RESP));
  assign accept    = accept_en && grant_found;
  assign req_ready = accept_en ? grant_vec : '0;

  // Pointer moves one past the winner so it becomes lowest priority next time.
  assign rr_ptr_nxt = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  assign cmp_triple = {cmp_gt, cmp_eq, cmp_lt};
  assign cmp_onehot = (cmp_triple == 3'b100) || (cmp_triple == 3'b010) ||
                      (cmp_triple == 3'b001);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: an accept always leads to ISSUE, ISSUE always to RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs: busy during ISSUE, response pulse to the owner during RESP.
  always_comb begin
    busy      = 1'b0;
    rsp_valid = '0;
    case (state)
      ST_ISSUE: busy = 1'b1;
      ST_RESP:  rsp_valid[owner_id] = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: latch winner's operands on accept, capture comparator result in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      owner_id <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      rsp_gt   <= 1'b0;
      rsp_eq   <= 1'b0;
      rsp_lt   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr   <= rr_ptr_nxt;
        owner_id <= grant_idx;
        cmp_a    <= op_a[grant_idx];
        cmp_b    <= op_b[grant_idx];
      end
      if (state == ST_ISSUE) begin
        rsp_gt <= cmp_gt;
        rsp_eq <= cmp_eq;
        rsp_lt <= cmp_lt;
        // A malformed result is still forwarded raw; err stays set until reset.
        if (!cmp_onehot) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Purpose: directed self-checking bench for cmp_share_arbiter with a behavioural comparator.
// Latency: stimulus driven on negedge, outputs sampled 1 time unit later.
// Backpressure: bench requesters hold valid until ready and always accept responses.
module tb_cmp_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic           cmp_gt;
  logic           cmp_eq;
  logic           cmp_lt;
  logic [N-1:0]   rsp_valid;
  logic           rsp_gt;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           busy;
  logic           err;

  logic           force_en;
  logic [2:0]     force_val;

  int n_chk  = 0;
  int n_fail = 0;

  cmp_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_gt    (cmp_gt),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .rsp_valid (rsp_valid),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Shared comparator model, with an override to inject malformed results.
  assign {cmp_gt, cmp_eq, cmp_lt} = force_en ? force_val :
                                    {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One isolated request: accept, ISSUE, RESP, then back to IDLE.
  task automatic do_single(input string tag, input int idx, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] want);
    logic [N-1:0] sel;
    sel = N'(1) << idx;
    @(negedge clk);
    set_op(idx, a, b);
    req_valid = sel;
    #1;
    check({tag, "_ready"}, req_ready, sel);
    check({tag, "_busy_idle"}, busy, 1'b0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, "_busy_issue"}, busy, 1'b1);
    check({tag, "_cmp_a"}, cmp_a, a);
    check({tag, "_cmp_b"}, cmp_b, b);
    check({tag, "_rsp_quiet"}, rsp_valid, '0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"}, rsp_valid, sel);
    check({tag, "_rsp_res"}, {rsp_gt, rsp_eq, rsp_lt}, want);
    check({tag, "_busy_resp"}, busy, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_end"}, rsp_valid, '0);
    check({tag, "_res_hold"}, {rsp_gt, rsp_eq, rsp_lt}, want);
  endtask

  // Continuous-load expectations, one entry per cycle after reset release.
  logic [N-1:0] exp_rdy [13];
  logic [N-1:0] exp_rsp [13];
  logic [2:0]   exp_res [13];

  initial begin
    exp_rdy = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000,
                4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    exp_rsp = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    exp_res = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b010,
                3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001};

    force_en  = 1'b0;
    force_val = 3'b000;
    req_a     = '0;
    req_b     = '0;
    req_valid = 4'b1111;

    // Reset state, with all requesters asserting valid.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cmp", {cmp_a, cmp_b}, 16'h0000);
    check("rst_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);

    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single requester 0, then requester 2 across eq / lt / unsigned boundary.
    do_single("r0_gt", 0, 8'h5A, 8'h3C, 3'b100);
    do_single("r2_eq", 2, 8'h77, 8'h77, 3'b010);
    do_single("r2_lt", 2, 8'h00, 8'hFF, 3'b001);
    do_single("r2_gt", 2, 8'hFF, 8'h00, 3'b100);

    // All four requesters valid from reset: back-to-back grants 0,1,2,3,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 8'(i * 'h11), 8'h22);
    req_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 11) req_valid = '0;
      #1;
      check($sformatf("load_ready_c%0d", k), req_ready, exp_rdy[k]);
      check($sformatf("load_rsp_c%0d", k), rsp_valid, exp_rsp[k]);
      if (exp_rsp[k] != '0) begin
        check($sformatf("load_res_c%0d", k), {rsp_gt, rsp_eq, rsp_lt}, exp_res[k]);
      end
    end

    // rr_ptr is now 2: requesters 0 and 3 valid -> 3 first, then 0.
    @(negedge clk);
    set_op(0, 8'h10, 8'h20);
    set_op(3, 8'h80, 8'h7F);
    req_valid = 4'b1001;
    #1;
    check("rr_first_ready", req_ready, 4'b1000);
    @(negedge clk);
    #1;
    check("rr_issue3_ready", req_ready, 4'b0000);
    check("rr_issue3_cmp_a", cmp_a, 8'h80);
    @(negedge clk);
    #1;
    check("rr_rsp3", rsp_valid, 4'b1000);
    check("rr_rsp3_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b100);
    check("rr_second_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rr_issue0_cmp_a", cmp_a, 8'h10);
    @(negedge clk);
    #1;
    check("rr_rsp0", rsp_valid, 4'b0001);
    check("rr_rsp0_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b001);

    // Reset asserted mid-ISSUE for requester 1 (rr_ptr is 1 here).
    @(negedge clk);
    set_op(1, 8'h44, 8'h40);
    set_op(0, 8'h01, 8'h02);
    req_valid = 4'b0010;
    #1;
    check("mid_rst_ready1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    check("mid_rst_busy_before", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp", rsp_valid, 4'b0000);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_cmp", {cmp_a, cmp_b}, 16'h0000);
    check("mid_rst_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
    @(negedge clk);
    #1;
    check("mid_rst_no_rsp", rsp_valid, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("post_rst_rsp_quiet", rsp_valid, 4'b0000);
    check("post_rst_cmp_a", cmp_a, 8'h01);
    @(negedge clk);
    #1;
    check("post_rst_rsp", rsp_valid, 4'b0001);
    check("post_rst_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b001);

    // Malformed comparator results set sticky err; responses still delivered raw.
    check("err_clean", err, 1'b0);
    force_en  = 1'b1;
    force_val = 3'b000;
    do_single("bad000", 1, 8'h10, 8'h10, 3'b000);
    check("err_after_000", err, 1'b1);
    force_val = 3'b110;
    do_single("bad110", 2, 8'h20, 8'h30, 3'b110);
    check("err_after_110", err, 1'b1);
    force_en = 1'b0;
    do_single("good_after_bad", 3, 8'h09, 8'h03, 3'b100);
    check("err_sticky", err, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("err_cleared", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
